imem_uart_loader: RTL and testbench

//  UART boot loader sitting directly upstream of the SoC instruction RAM. While load_imem is high it

---
 rtl/imem_uart_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a framed program image (8N1), assembles little-endian
// words and writes them into the instruction RAM while holding the CPU in reset.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int IMEM_AW        = 14,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rxd,
    input  logic               load_imem,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);
    localparam int BTW = $clog2(CLKS_PER_BIT);
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(CLKS_PER_BIT - 1);
    localparam logic [BTW-1:0] HALF_LAST = BTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]    MAX_WORDS = 17'(2**IMEM_AW);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CNT0, S_CNT1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    rx_state_t      rx_state_q;
    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BTW-1:0] rx_timer_q;
    logic [2:0]     rx_bit_q;
    logic [7:0]     rx_shift_q;
    logic           byte_valid_q, frame_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_timer_q   <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rxd;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_timer_q <= HALF_LAST;
                    end
                end
                RX_START: begin
                    // mid-bit re-check rejects short low glitches
                    if (rx_timer_q != '0) begin
                        rx_timer_q <= rx_timer_q - BTW'(1);
                    end else if (rx_sync_q) begin
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_state_q <= RX_DATA;
                        rx_timer_q <= BIT_LAST;
                        rx_bit_q   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_timer_q != '0) begin
                        rx_timer_q <= rx_timer_q - BTW'(1);
                    end else begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_timer_q <= BIT_LAST;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_timer_q != '0) begin
                        rx_timer_q <= rx_timer_q - BTW'(1);
                    end else begin
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q   <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    state_t           state_q;
    logic [15:0]      n_q;
    logic [IMEM_AW:0] widx_q;
    logic [1:0]       bcnt_q;
    logic [7:0]       sum_q;
    logic [TMW-1:0]   tmo_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [IMEM_AW-1:0] addr_q;
    logic             hold_q, done_q, err_q;

    logic [7:0]  sum_d;
    logic [16:0] n_d;
    logic        last_word;

    assign sum_d     = sum_q + rx_shift_q;
    assign n_d       = {1'b0, rx_shift_q, n_q[7:0]};
    assign last_word = (17'(widx_q) + 17'd1) == {1'b0, n_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_imem) begin
                        state_q <= S_HDR;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_DONE: if (!load_imem) state_q <= S_IDLE;
                S_ERR: begin
                    if (!load_imem) begin
                        state_q <= S_IDLE;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    // HDR..CSUM: abort beats framing error beats data beats timeout
                    if (!load_imem) begin
                        state_q <= S_IDLE;
                        hold_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (frame_err_q && state_q != S_HDR) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else if (byte_valid_q) begin
                        tmo_q <= TMO_LAST;
                        sum_q <= sum_d;
                        case (state_q)
                            S_HDR: begin
                                if (rx_shift_q == 8'hA5) begin
                                    state_q <= S_CNT0;
                                    sum_q   <= '0;
                                end
                            end
                            S_CNT0: begin
                                n_q[7:0] <= rx_shift_q;
                                state_q  <= S_CNT1;
                            end
                            S_CNT1: begin
                                n_q[15:8] <= rx_shift_q;
                                if (n_d > MAX_WORDS) begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end else if (n_d == 17'd0) begin
                                    state_q <= S_CSUM;
                                end else begin
                                    state_q <= S_DATA;
                                    widx_q  <= '0;
                                    bcnt_q  <= '0;
                                end
                            end
                            S_DATA: begin
                                wdata_q <= {rx_shift_q, wdata_q[31:8]};
                                bcnt_q  <= bcnt_q + 2'd1;
                                if (bcnt_q == 2'd3) begin
                                    we_q   <= 1'b1;
                                    addr_q <= widx_q[IMEM_AW-1:0];
                                    widx_q <= widx_q + (IMEM_AW+1)'(1);
                                    if (last_word) state_q <= S_CSUM;
                                end
                            end
                            S_CSUM: begin
                                if (sum_d == 8'd0) begin
                                    state_q <= S_DONE;
                                    hold_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (state_q != S_HDR) begin
                        if (tmo_q == '0) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q - TMW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed frame table, randomized frames checked against a
// frame-parsing reference model, and hand sequences for glitch, timeout, reset and abort.
module tb_imem_uart_loader;
    localparam int CPB  = 8;
    localparam int AW   = 4;
    localparam int TMO  = 1000;
    localparam int MAXW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_rxd;
    logic          load_imem;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, load_done, load_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_q[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_words[$];
    bit          exp_done, exp_err;

    typedef struct {
        int n;
        int junk;
        bit bad;
        bit e_done;
        bit e_err;
        int e_writes;
    } vec_t;
    vec_t vecs[7];

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .IMEM_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .load_imem(load_imem),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_data_at(input int i);
        if (i < wr_data_q.size()) return wr_data_q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] wr_addr_at(input int i);
        if (i < wr_addr_q.size()) return 32'(wr_addr_q[i]);
        return 'x;
    endfunction

    // Reference: parse the byte stream as a frame and derive the outcome.
    function automatic void model();
        int i;
        int n;
        logic [7:0] sum;
        exp_words.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
        if (i + 3 > tx_q.size()) return;
        n   = int'(tx_q[i+1]) + 256 * int'(tx_q[i+2]);
        sum = tx_q[i+1] + tx_q[i+2];
        i   = i + 3;
        if (n > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_words.push_back({tx_q[i+3], tx_q[i+2], tx_q[i+1], tx_q[i]});
            sum = sum + tx_q[i] + tx_q[i+1] + tx_q[i+2] + tx_q[i+3];
            i = i + 4;
        end
        sum = sum + tx_q[i];
        exp_done = (sum == 8'd0);
        exp_err  = !exp_done;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic glitch();
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic build_frame(input int n, input int junk, input bit bad);
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [31:0] w;
        tx_q.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            tx_q.push_back(b);
        end
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        if (n > MAXW) return;
        sum = n[7:0] + n[15:8];
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                b = w[8*j +: 8];
                tx_q.push_back(b);
                sum = sum + b;
            end
        end
        b = 8'd0 - sum;
        if (bad) b = b + 8'd1 + 8'($urandom_range(0, 254));
        tx_q.push_back(b);
    endtask

    task automatic run_load(input string tag, input bit bad_hdr, input bit e_done,
                            input bit e_err, input int e_writes);
        model();
        wr_addr_q.delete();
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        check_bit({tag, " hold at start"}, cpu_hold, 1'b1);
        check_bit({tag, " done cleared"}, load_done, 1'b0);
        check_bit({tag, " err cleared"}, load_err, 1'b0);
        if (bad_hdr) send_byte(8'hA5, 1'b0);
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        repeat (4) @(negedge clk);
        check_bit({tag, " load_done"}, load_done, e_done);
        check_bit({tag, " load_err"}, load_err, e_err);
        check_bit({tag, " cpu_hold"}, cpu_hold, !e_done);
        check_word({tag, " write count"}, 32'(wr_data_q.size()), 32'(e_writes));
        for (int w = 0; w < exp_words.size(); w++) begin
            check_word($sformatf("%s addr[%0d]", tag, w), wr_addr_at(w), 32'(w));
            check_word($sformatf("%s data[%0d]", tag, w), wr_data_at(w), exp_words[w]);
        end
    endtask

    task automatic finish_load(input string tag, input bit e_done);
        load_imem = 1'b0;
        repeat (3) @(negedge clk);
        check_bit({tag, " hold after drop"}, cpu_hold, 1'b0);
        check_bit({tag, " done sticky"}, load_done, e_done);
    endtask

    initial begin
        vecs[0] = '{1,     0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{16,    0, 1'b0, 1'b1, 1'b0, 16};
        vecs[2] = '{0,     0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{3,     0, 1'b1, 1'b0, 1'b1, 3};
        vecs[4] = '{17,    0, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{2,     3, 1'b0, 1'b1, 1'b0, 2};
        vecs[6] = '{65535, 0, 1'b0, 1'b0, 1'b1, 0};

        reset = 1'b0;
        uart_rxd = 1'b1;
        load_imem = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset imem_we", imem_we, 1'b0);
        check_word("reset imem_addr", 32'(imem_addr), 32'd0);
        check_word("reset imem_wdata", imem_wdata, 32'd0);
        check_bit("reset cpu_hold", cpu_hold, 1'b0);
        check_bit("reset load_done", load_done, 1'b0);
        check_bit("reset load_err", load_err, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Two-word image with exact contents; loader must not restart while load_imem stays high.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        run_load("t1", 1'b0, 1'b1, 1'b0, 2);
        check_word("t1 word0", wr_data_at(0), 32'h0000_0013);
        check_word("t1 word1", wr_data_at(1), 32'h0000_006F);
        repeat (40) @(negedge clk);
        check_bit("t1 no restart done", load_done, 1'b1);
        check_bit("t1 no restart hold", cpu_hold, 1'b0);
        finish_load("t1", 1'b1);

        tx_q[11] = 8'h7F;
        run_load("t2 bad csum", 1'b0, 1'b0, 1'b1, 2);
        repeat (20) @(negedge clk);
        check_bit("t2 hold while load high", cpu_hold, 1'b1);
        finish_load("t2", 1'b0);

        for (int v = 0; v < 7; v++) begin
            build_frame(vecs[v].n, vecs[v].junk, vecs[v].bad);
            run_load($sformatf("vec%0d", v), 1'b0, vecs[v].e_done, vecs[v].e_err, vecs[v].e_writes);
            finish_load($sformatf("vec%0d", v), vecs[v].e_done);
        end

        for (int r = 0; r < 8; r++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 300)) : int'($urandom_range(0, 6));
            build_frame(n, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            model();
            run_load($sformatf("rnd%0d", r), 1'b0, exp_done, exp_err, exp_words.size());
            finish_load($sformatf("rnd%0d", r), exp_done);
        end

        // Framing error while hunting for the header is dropped silently.
        build_frame(1, 0, 1'b0);
        run_load("hdr frame err", 1'b1, 1'b1, 1'b0, 1);
        finish_load("hdr frame err", 1'b1);

        // Glitches in HDR and between data bytes; 0x55 before the header is skipped.
        wr_addr_q.delete();
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        glitch();
        send_byte(8'h55, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        glitch();
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        glitch();
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        glitch();
        send_byte(8'hC7, 1'b1);
        repeat (4) @(negedge clk);
        check_word("glitch write count", 32'(wr_data_q.size()), 32'd1);
        check_word("glitch data", wr_data_at(0), 32'hDEAD_BEEF);
        check_bit("glitch done", load_done, 1'b1);
        finish_load("glitch", 1'b1);

        // Inter-byte timeout in DATA.
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (990) @(negedge clk);
        check_bit("timeout not early", load_err, 1'b0);
        check_bit("timeout hold", cpu_hold, 1'b1);
        for (int i = 0; i < 20 && load_err !== 1'b1; i++) @(negedge clk);
        check_bit("timeout err", load_err, 1'b1);
        check_word("timeout writes", 32'(wr_data_q.size()), 32'd0);
        finish_load("timeout", 1'b0);

        // Reset asserted mid-DATA after two words have been written.
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        tx_q = '{8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'h88, 8'h77, 8'h66, 8'h55, 8'hAA, 8'hBB};
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        check_word("pre-reset writes", 32'(wr_data_q.size()), 32'd2);
        check_word("pre-reset wdata", imem_wdata, 32'hBBAA_5566);
        uart_rxd = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("mid reset imem_we", imem_we, 1'b0);
        check_word("mid reset imem_addr", 32'(imem_addr), 32'd0);
        check_word("mid reset imem_wdata", imem_wdata, 32'd0);
        check_bit("mid reset cpu_hold", cpu_hold, 1'b0);
        check_bit("mid reset load_done", load_done, 1'b0);
        check_bit("mid reset load_err", load_err, 1'b0);
        load_imem = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check_word("post-reset writes", 32'(wr_data_q.size()), 32'd2);
        check_bit("post-reset hold", cpu_hold, 1'b0);

        // Framing error in DATA, then a clean reload.
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check_bit("data frame err", load_err, 1'b1);
        check_bit("data frame err done", load_done, 1'b0);
        check_bit("data frame err hold", cpu_hold, 1'b1);
        check_word("data frame err writes", 32'(wr_data_q.size()), 32'd0);
        finish_load("data frame err", 1'b0);
        build_frame(2, 0, 1'b0);
        run_load("reload", 1'b0, 1'b1, 1'b0, 2);
        finish_load("reload", 1'b1);

        // load_imem dropped mid-frame aborts with an error.
        wr_data_q.delete();
        load_imem = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAB, 1'b1);
        load_imem = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("abort err", load_err, 1'b1);
        check_bit("abort hold", cpu_hold, 1'b0);
        check_bit("abort done", load_done, 1'b0);
        check_word("abort writes", 32'(wr_data_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
